// File: rtl/reg_bank_8.sv
// Eight-entry register bank feeding the datapath 8:1 mux, with a single-op
// command port and a multi-cycle clear-all sweep guarded by busy.
module reg_bank_8 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [2:0]   op,
    input  logic [2:0]   addr,
    input  logic [2:0]   src,
    input  logic [N-1:0] din,
    output logic         busy,
    output logic         ack,
    output logic         done,
    output logic         zf,
    output logic [N-1:0] r0,
    output logic [N-1:0] r1,
    output logic [N-1:0] r2,
    output logic [N-1:0] r3,
    output logic [N-1:0] r4,
    output logic [N-1:0] r5,
    output logic [N-1:0] r6,
    output logic [N-1:0] r7
);

    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_CLR    = 3'b010;
    localparam logic [2:0] OP_INC    = 3'b011;
    localparam logic [2:0] OP_DEC    = 3'b100;
    localparam logic [2:0] OP_MOV    = 3'b101;
    localparam logic [2:0] OP_CLRALL = 3'b110;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t       state;
    logic [2:0]   cnt;
    logic [N-1:0] regs [8];
    logic [N-1:0] wval;
    logic         wr;

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

    // Next value for the destination; MOV reads the pre-edge source value.
    always_comb begin
        wval = regs[addr];
        wr   = 1'b1;
        case (op)
            OP_LOAD: wval = din;
            OP_CLR:  wval = '0;
            OP_INC:  wval = regs[addr] + N'(1);
            OP_DEC:  wval = regs[addr] - N'(1);
            OP_MOV:  wval = regs[src];
            default: wr   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ack   <= 1'b0;
            done  <= 1'b0;
            zf    <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            ack  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        if (op == OP_CLRALL) begin
                            state <= SWEEP;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end else begin
                            ack <= 1'b1;
                            if (wr) begin
                                regs[addr] <= wval;
                                zf         <= (wval == '0);
                            end
                        end
                    end
                end
                SWEEP: begin
                    regs[cnt] <= '0;
                    cnt       <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ack   <= 1'b1;
                        zf    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_8.sv
// Bench for reg_bank_8: table vectors, hand sequences for sweep/reset corners,
// and random commands scored against an array-based reference model.
module tb_reg_bank_8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [2:0] op = '0, addr = '0, src = '0;
    logic [7:0] din = '0;
    logic       busy, ack, done, zf;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;

    reg_bank_8 #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .addr(addr), .src(src), .din(din),
        .busy(busy), .ack(ack), .done(done), .zf(zf),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int m_regs [8];
    bit m_busy, m_ack, m_done, m_zf;
    int m_idx;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_busy = 0; m_ack = 0; m_done = 0; m_zf = 0; m_idx = 0;
    endfunction

    function automatic void model_edge(bit e, int o, int a, int s, int d);
        int v;
        m_ack = 0; m_done = 0;
        if (m_busy) begin
            m_regs[m_idx] = 0;
            m_idx++;
            if (m_idx == 8) begin
                m_busy = 0; m_done = 1; m_ack = 1; m_zf = 1;
            end
        end else if (e) begin
            if (o == 6) begin
                m_busy = 1; m_idx = 0;
            end else begin
                m_ack = 1;
                if (o >= 1 && o <= 5) begin
                    case (o)
                        1: v = d;
                        2: v = 0;
                        3: v = (m_regs[a] + 1) % 256;
                        4: v = (m_regs[a] + 255) % 256;
                        default: v = m_regs[s];
                    endcase
                    m_regs[a] = v;
                    m_zf = (v == 0);
                end
            end
        end
    endfunction

    function automatic logic [7:0] dr(int i);
        case (i)
            0: return r0; 1: return r1; 2: return r2; 3: return r3;
            4: return r4; 5: return r5; 6: return r6; default: return r7;
        endcase
    endfunction

    task automatic check(string name);
        logic [63:0] act, exp;
        logic [3:0]  fa, fe;
        for (int i = 0; i < 8; i++) begin
            act[i*8 +: 8] = dr(i);
            exp[i*8 +: 8] = 8'(m_regs[i]);
        end
        fa = {busy, ack, done, zf};
        fe = {m_busy, m_ack, m_done, m_zf};
        n_vec++;
        if (fa !== fe || act !== exp) begin
            n_bad++;
            $display("FAIL %s: got busy/ack/done/zf=%b regs=%h, expected %b regs=%h",
                     name, fa, act, fe, exp);
        end
    endtask

    task automatic step(bit e, int o, int a, int s, int d, string name);
        en = e; op = 3'(o); addr = 3'(a); src = 3'(s); din = 8'(d);
        @(posedge clk);
        model_edge(e, o, a, s, d);
        #1;
        check(name);
    endtask

    task automatic expect_val(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit en; int op; int addr; int src; int din;
        bit ack; bit zf; int val;
    } vec_t;

    vec_t tbl [13];
    int   bc, dc;

    initial begin
        tbl[0]  = '{1, 1, 3, 0, 8'hA5, 1, 0, 8'hA5};
        tbl[1]  = '{1, 5, 6, 3, 0,     1, 0, 8'hA5};
        tbl[2]  = '{1, 0, 3, 0, 0,     1, 0, 8'hA5};
        tbl[3]  = '{1, 1, 1, 0, 8'hFF, 1, 0, 8'hFF};
        tbl[4]  = '{1, 3, 1, 0, 0,     1, 1, 8'h00};
        tbl[5]  = '{1, 4, 1, 0, 0,     1, 0, 8'hFF};
        tbl[6]  = '{1, 2, 5, 0, 0,     1, 1, 8'h00};
        tbl[7]  = '{1, 4, 5, 0, 0,     1, 0, 8'hFF};
        tbl[8]  = '{1, 7, 5, 0, 8'h12, 1, 0, 8'hFF};
        tbl[9]  = '{1, 5, 3, 3, 0,     1, 0, 8'hA5};
        tbl[10] = '{0, 1, 3, 0, 8'h00, 0, 0, 8'hA5};
        tbl[11] = '{1, 1, 0, 0, 8'h00, 1, 1, 8'h00};
        tbl[12] = '{1, 0, 0, 0, 0,     1, 1, 8'h00};

        model_reset();
        #2;
        check("reset_state");
        #10 rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].op, tbl[i].addr, tbl[i].src, tbl[i].din, "table_model");
            expect_val($sformatf("table%0d_ack", i), int'(ack), int'(tbl[i].ack));
            expect_val($sformatf("table%0d_zf", i), int'(zf), int'(tbl[i].zf));
            expect_val($sformatf("table%0d_reg", i), int'(dr(tbl[i].addr)), tbl[i].val);
        end
        expect_val("mov_src_kept", int'(r3), 8'hA5);

        // Sweep with a LOAD ignored on sweep cycle 3, then accepted right after.
        for (int i = 0; i < 8; i++) step(1, 1, i, 0, i + 1, "sweep_preload");
        step(1, 6, 0, 0, 0, "clrall_accept");
        bc = int'(busy); dc = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) step(1, 1, 2, 0, 8'h55, "sweep_en_ignored");
            else        step(0, 0, 0, 0, 0, "sweep_cycle");
            expect_val($sformatf("sweep_r%0d_cleared", k - 1), int'(dr(k - 1)), 0);
            if (k < 8) expect_val($sformatf("sweep_r%0d_pending", k), int'(dr(k)), k + 1);
            bc += int'(busy); dc += int'(done);
        end
        expect_val("sweep_busy_cycles", bc, 8);
        expect_val("sweep_done_pulses", dc, 1);
        expect_val("sweep_zf", int'(zf), 1);
        step(1, 1, 2, 0, 8'h55, "load_after_busy");
        expect_val("load_after_busy_r2", int'(r2), 8'h55);
        expect_val("load_after_busy_ack", int'(ack), 1);

        // Asynchronous reset in the middle of a sweep.
        step(1, 6, 0, 0, 0, "clrall_accept2");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, "sweep_pre_reset");
        #3 rst_n = 1'b0;
        #1 model_reset();
        check("reset_mid_sweep");
        #2 rst_n = 1'b1;
        step(1, 1, 4, 0, 8'h3C, "load_after_reset");
        expect_val("load_after_reset_ack", int'(ack), 1);

        // Async reset with random contents, checked before any clock edge.
        for (int i = 0; i < 8; i++) step(1, 1, i, 0, $urandom_range(1, 255), "rand_preload");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("reset_async_random");
        #3 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            int o;
            o = ($urandom_range(0, 15) == 0) ? 6 : $urandom_range(0, 7);
            if (o == 6 && $urandom_range(0, 1) == 0) o = 1;
            step($urandom_range(0, 3) != 0, o, $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_8.md
Name: reg_bank_8

Overview:
Bank of eight N-bit registers whose outputs R0..R7 drive the eight data inputs of the processor's 8:1 datapath multiplexer directly, one register per mux input. A one-op-per-cycle command port performs load, clear, increment, decrement and register-to-register move. A multi-cycle clear-all sweep runs under a BUSY handshake. The controller issues commands here; the mux select is driven separately by the controller.

Parameters:
N, 8, register and data width in bits

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  command valid; sampled on rising CLK
OP  input  3  command code, see Behaviour
ADDR  input  3  destination register index
SRC  input  3  source register index (MOV only)
DIN  input  N  load data (LOAD only)
BUSY  output  1  high while clear-all sweep in progress; EN ignored
ACK  output  1  one-cycle pulse: command accepted/completed
DONE  output  1  one-cycle pulse on final sweep cycle
ZF  output  1  registered zero flag of last written value
R0..R7  output  N each  register contents, to mux inputs I0..I7

Behaviour:
- Reset (RST_N=0, asynchronous, any time incl. mid-sweep): R0..R7=0, BUSY=0, ACK=0, DONE=0, ZF=0, FSM=IDLE, sweep counter=0.
- All updates on rising CLK; outputs are registers (no combinational path from inputs to outputs).
- Accept: EN=1 and FSM=IDLE. Accepted command takes effect at that edge; ACK=1 for the following cycle only. EN=0 or not accepted -> ACK=0.
- OP codes (single-cycle, destination R[ADDR]):
  - 000 NOP: no register change; ACK still pulses, ZF unchanged.
  - 001 LOAD: R[ADDR]<=DIN.
  - 010 CLR: R[ADDR]<=0.
  - 011 INC: R[ADDR]<=R[ADDR]+1 mod 2^N (all-ones wraps to 0).
  - 100 DEC: R[ADDR]<=R[ADDR]-1 mod 2^N (0 wraps to all-ones).
  - 101 MOV: R[ADDR]<=R[SRC], using the pre-edge value of R[SRC]. SRC=ADDR leaves the register unchanged but ACK and ZF still update.
  - 110 CLRALL: start sweep (below).
  - 111 reserved: treated as NOP (ACK pulses, no change).
- ZF: after any writing op (001-101), ZF<=(new value==0). NOP, reserved and CLRALL acceptance leave ZF unchanged; ZF<=1 on the DONE cycle.
- FSM states:
  - IDLE: CLRALL accepted -> SWEEP, counter<=0, BUSY<=1.
  - SWEEP: each cycle R[counter]<=0, counter++. When counter==7: clear R7, DONE<=1 for the next cycle, ACK<=1 for the next cycle, BUSY<=0, -> IDLE.
  - BUSY is high for exactly 8 cycles. Registers clear in index order R0 first, R7 last, one per cycle.
- EN during SWEEP: ignored, no ACK, no register change. The command is not queued.
- EN on the cycle BUSY falls (FSM already IDLE): accepted normally.
- Only one write per cycle exists, so no write-port collision is possible.

Test Plan:
- Reset: drive RST_N low mid-cycle with random register contents -> all R=0, BUSY/ACK/DONE/ZF=0 immediately, without waiting for a clock edge.
- LOAD/MOV: LOAD R3=0xA5, then MOV ADDR=6 SRC=3 -> R6=0xA5, R3 unchanged, ACK pulses once per command, ZF=0.
- Wrap: LOAD R1=0xFF, INC R1 -> R1=0x00, ZF=1; DEC R1 -> R1=0xFF, ZF=0.
- Sweep: load R0..R7=1..8, issue CLRALL -> BUSY high 8 cycles, R0..R7 reach 0 in order one per cycle, DONE and ACK pulse once at the end, ZF=1.
- EN during sweep: LOAD R2=0x55 issued on sweep cycle 3 -> ignored, no ACK, R2 ends at 0. The same LOAD issued on the first cycle after BUSY falls -> R2=0x55 with ACK.
- Reset mid-sweep: assert RST_N low at sweep cycle 4 -> BUSY=0, FSM=IDLE; after release, a LOAD is accepted on the first enabled cycle.
